cut_bist_ctrl: RTL
==================

Name: cut_bist_ctrl

Overview:
Parametrised logic-BIST controller for a combinational benchmark cone (circuit-under-test, CUT) of arbitrary input and output width. A Galois LFSR drives the CUT inputs for a programmed number of patterns. A MISR compacts the CUT responses, and the final signature is compared against a golden value. It sits between the fault-injection/test harness and any converted-combinational cone, and replaces manual per-output stimulus with self-test over all outputs and CUT pipeline depths.

Parameters:
N_IN, 22, CUT input width = LFSR width (>=2)
N_OUT, 1, CUT output width (1..MISR_W)
MISR_W, 16, MISR/signature width
LFSR_POLY, 22'h200001, Galois feedback mask for LFSR (N_IN bits)
MISR_POLY, 16'hB400, Galois feedback mask for MISR (MISR_W bits)
PAT_W, 16, pattern counter width
CUT_LAT, 0, CUT register stages (0..7); 0 = purely combinational cone

Ports:
CK  in  1  clock, rising edge
RN  in  1  asynchronous active-low reset
start  in  1  begin a run; sampled only in IDLE
abort  in  1  synchronous abort to IDLE from any state
seed  in  N_IN  LFSR seed, sampled in LOAD
num_pat  in  PAT_W  patterns to apply, sampled in LOAD
golden  in  MISR_W  expected signature
cut_in  out  N_IN  stimulus to CUT (= LFSR register)
cut_out  in  N_OUT  CUT response
busy  out  1  high in LOAD/RUN/DRAIN
done  out  1  high in DONE
pass  out  1  valid in DONE: signature == golden
signature  out  MISR_W  MISR register
pat_cnt  out  PAT_W  patterns issued so far

Behaviour:
- Interface: one clock CK; reset RN is asynchronous and active-low.
- Reset (RN low, immediate): state IDLE; lfsr, misr, pat_cnt, valid pipe = 0; busy/done/pass = 0. This applies mid-run too: no partial signature is retained.
- States: IDLE -> LOAD -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 -> LOAD.
- LOAD (1 cycle):
  - lfsr <= seed, or all-ones if seed==0 (lock-up avoidance).
  - misr <= 0; pat_cnt <= 0; latched count <= num_pat.
  - Next state is RUN, or DRAIN if num_pat==0.
- RUN:
  - Each cycle the current lfsr value is one applied pattern, and a 1 enters the valid pipe.
  - At each edge: lfsr <= (lfsr>>1) ^ (lfsr[0] ? LFSR_POLY : 0); pat_cnt++.
  - When pat_cnt reaches count-1, go to DRAIN (RUN lasts exactly num_pat cycles).
- Valid pipe: a shift register of depth CUT_LAT. Its output tap (the RUN flag itself when CUT_LAT=0) qualifies cut_out.
- MISR update, when the tap is 1: misr <= (misr>>1) ^ (misr[0] ? MISR_POLY : 0) ^ zero-extend(cut_out). With the tap 0, misr holds.
- DRAIN: lasts CUT_LAT cycles, feeds 0 into the valid pipe, and the lfsr holds. With CUT_LAT=0 it lasts 1 idle cycle and no absorption. Then DONE.
- DONE:
  - done=1; pass = (misr==golden), registered on DONE entry; signature is stable.
  - Stays in DONE until start=0, then -> IDLE. done, pass and signature are held until the next LOAD.
- abort=1 in any non-IDLE state: next state IDLE; busy=0 and done=0 next cycle; lfsr/misr/pat_cnt retain their values. abort has priority over start and all transitions.
- start held high through DONE does not restart; a new run needs start to go low, then high.
- pat_cnt saturates nowhere; num_pat max = 2^PAT_W-1.
- cut_in is a register output: no combinational path from any input to any output.

Decomposition:
- Shared package bist_pkg: state enum (IDLE, LOAD, RUN, DRAIN, DONE); galois_step function (value, mask, width).
- One sub-module, galois_reg: a width-parametrised shift register with a mask. It is instantiated twice, once as the LFSR (injection input tied 0) and once as the MISR (injection = cut_out). The controller FSM and valid pipe stay in the top.

Test Plan:
- LFSR period (N_IN=4, LFSR_POLY=4'hC, seed=4'h1, num_pat=15): cut_in sequence 1,C,6,3,D,A,5,E,7,F,B,9,8,4,2, then lfsr==4'h1 in DONE.
- MISR (N_OUT=1, MISR_W=4, MISR_POLY=4'hC, cut_out=1, num_pat=3, CUT_LAT=0): signature==4'hB. With golden=4'hB, pass=1; with golden=4'hA, pass=0.
- Latency (same as the previous run, CUT_LAT=2, CUT modelled as a 2-stage delay of lfsr[0]): signature equals that of the CUT_LAT=0 run with a combinational lfsr[0]. DRAIN lasts 2 cycles; busy stays high for 1+3+2 cycles.
- Corners:
  - seed=0 -> first cut_in is all-ones.
  - num_pat=0 -> DONE with signature 0; pass==(golden==0).
- abort in RUN at pat_cnt=5 -> IDLE next cycle, done=0. Then start -> full run matches a clean-run signature.
- RN pulsed low mid-RUN -> busy, done, pass, pat_cnt and signature all 0 immediately (asynchronous). start held high through DONE -> no second run until start toggles.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared definitions for the logic-BIST controller: FSM state encoding and Galois step.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Widest shift register the helper below handles; callers zero-extend into it.
    localparam int GALOIS_MAX_W = 64;

    // One Galois (right-shifting) step: shift toward bit 0 and, if the bit
    // shifted out was 1, XOR the feedback mask in. Bits at or above `width`
    // are forced to zero so a narrow register never picks up stray bits.
    function automatic logic [GALOIS_MAX_W-1:0] galois_step(
        input logic [GALOIS_MAX_W-1:0] value,
        input logic [GALOIS_MAX_W-1:0] mask,
        input int                      width
    );
        logic [GALOIS_MAX_W-1:0] keep;
        if (width >= GALOIS_MAX_W) begin
            keep = '1;
        end else begin
            keep = (64'd1 << width) - 64'd1;
        end
        return ((value >> 1) ^ (value[0] ? mask : '0)) & keep;
    endfunction

endpackage

// File: rtl/galois_reg.sv
// Width-parametrised Galois shift register with parallel load and an injection input (LFSR or MISR).
// Latency: 1 cycle from load/step to q; nxt is the combinational next value.
// Backpressure: none; q holds whenever neither load nor step is asserted.
//
// Ports:
//   CK, RN      clock, asynchronous active-low reset (q -> 0)
//   load        q <= load_val (has priority over step)
//   load_val    parallel load value
//   step        q <= galois_step(q) ^ inj
//   inj         word XORed in on a step (tie to 0 for a plain LFSR)
//   q           register value
//   nxt         value q takes at the next edge
module galois_reg
    import bist_pkg::*;
#(
    parameter int           W    = 16,
    parameter logic [W-1:0] MASK = '0
) (
    input  logic         CK,
    input  logic         RN,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         step,
    input  logic [W-1:0] inj,
    output logic [W-1:0] q,
    output logic [W-1:0] nxt
);

    logic [GALOIS_MAX_W-1:0] stepped;
    logic                    unused_stepped_hi;

    assign stepped = galois_step(GALOIS_MAX_W'(q), GALOIS_MAX_W'(MASK), W);
    // Upper bits are always zero for W < GALOIS_MAX_W; fold them away.
    assign unused_stepped_hi = ^stepped;

    always_comb begin
        nxt = q;
        if (load) begin
            nxt = load_val;
        end else if (step) begin
            nxt = stepped[W-1:0] ^ inj;
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            q <= '0;
        end else begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/cut_bist_ctrl.sv
// Logic-BIST controller: LFSR drives a CUT for num_pat patterns, MISR compacts responses, signature vs golden.
// Latency: 1 (LOAD) + num_pat (RUN) + max(CUT_LAT,1) (DRAIN) cycles from start to done.
// Backpressure: none; start is only sampled in IDLE and DONE waits for start to drop before returning to IDLE.
//
// Ports:
//   CK, RN      clock, asynchronous active-low reset
//   start       begin a run (IDLE only); abort returns to IDLE from any state
//   seed        LFSR seed (0 is replaced by all-ones), num_pat pattern count, golden expected signature
//   cut_in      stimulus to the CUT (LFSR register), cut_out CUT response
//   busy        LOAD/RUN/DRAIN; done/pass result flags; signature MISR register; pat_cnt patterns issued
module cut_bist_ctrl
    import bist_pkg::*;
#(
    parameter int                N_IN      = 22,
    parameter int                N_OUT     = 1,
    parameter int                MISR_W    = 16,
    parameter logic [N_IN-1:0]   LFSR_POLY = 22'h200001,
    parameter logic [MISR_W-1:0] MISR_POLY = 16'hB400,
    parameter int                PAT_W     = 16,
    parameter int                CUT_LAT   = 0
) (
    input  logic              CK,
    input  logic              RN,
    input  logic              start,
    input  logic              abort,
    input  logic [N_IN-1:0]   seed,
    input  logic [PAT_W-1:0]  num_pat,
    input  logic [MISR_W-1:0] golden,
    output logic [N_IN-1:0]   cut_in,
    input  logic [N_OUT-1:0]  cut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature,
    output logic [PAT_W-1:0]  pat_cnt
);

    // DRAIN is CUT_LAT cycles long, but never shorter than one cycle.
    localparam logic [2:0] DRAIN_LAST = (CUT_LAT == 0) ? 3'd0 : 3'(CUT_LAT - 1);

    state_t            state;
    logic [PAT_W-1:0]  pat_total;
    logic [2:0]        drain_cnt;
    logic              tap;

    logic              lfsr_load;
    logic              lfsr_step;
    logic [N_IN-1:0]   lfsr_seed;
    logic [N_IN-1:0]   lfsr_q;
    logic [N_IN-1:0]   lfsr_nxt_unused;

    logic              misr_step;
    logic [MISR_W-1:0] misr_inj;
    logic [MISR_W-1:0] misr_q;
    logic [MISR_W-1:0] misr_nxt;

    // An all-zero seed would lock the LFSR at zero.
    assign lfsr_seed = (seed == '0) ? '1 : seed;

    // abort freezes every datapath register on the edge it is seen.
    assign lfsr_load = (state == LOAD) && !abort;
    assign lfsr_step = (state == RUN) && !abort;
    assign misr_step = tap && !abort;
    assign misr_inj  = MISR_W'(cut_out);

    galois_reg #(
        .W    (N_IN),
        .MASK (LFSR_POLY)
    ) u_lfsr (
        .CK       (CK),
        .RN       (RN),
        .load     (lfsr_load),
        .load_val (lfsr_seed),
        .step     (lfsr_step),
        .inj      ('0),
        .q        (lfsr_q),
        .nxt      (lfsr_nxt_unused)
    );

    galois_reg #(
        .W    (MISR_W),
        .MASK (MISR_POLY)
    ) u_misr (
        .CK       (CK),
        .RN       (RN),
        .load     (lfsr_load),
        .load_val ('0),
        .step     (misr_step),
        .inj      (misr_inj),
        .q        (misr_q),
        .nxt      (misr_nxt)
    );

    assign cut_in    = lfsr_q;
    assign signature = misr_q;

    // Valid pipe: tracks which cycles carry a CUT response for an applied
    // pattern. With no CUT registers the RUN flag itself qualifies cut_out.
    generate
        if (CUT_LAT == 0) begin : g_no_pipe
            assign tap = (state == RUN);
        end else begin : g_pipe
            logic [CUT_LAT-1:0] vpipe;
            always_ff @(posedge CK or negedge RN) begin
                if (!RN) begin
                    vpipe <= '0;
                end else if (abort || state == LOAD) begin
                    vpipe <= '0;
                end else begin
                    vpipe <= CUT_LAT'({vpipe, (state == RUN)});
                end
            end
            assign tap = vpipe[CUT_LAT-1];
        end
    endgenerate

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state     <= IDLE;
            pat_cnt   <= '0;
            pat_total <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else if (abort && state != IDLE) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end
                end
                LOAD: begin
                    pat_cnt   <= '0;
                    pat_total <= num_pat;
                    drain_cnt <= '0;
                    state     <= (num_pat == '0) ? DRAIN : RUN;
                end
                RUN: begin
                    pat_cnt <= pat_cnt + PAT_W'(1);
                    if (pat_cnt == pat_total - PAT_W'(1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // The last response may be absorbed on this same
                        // edge, so compare against the MISR's next value.
                        pass  <= (misr_nxt == golden);
                    end else begin
                        drain_cnt <= drain_cnt + 3'd1;
                    end
                end
                DONE: begin
                    if (!start) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
